// File: rtl/speculative_history_table_pkg.sv
// Shared constants and the history shift-in helper used by every update path.
package speculative_history_table_pkg;

    localparam int DEFAULT_INDEX_LEN   = 7;
    localparam int DEFAULT_HISTORY_LEN = 10;

    // The helper works on a fixed-width word. Callers zero-extend their history
    // into it and size-cast the result back, which drops the old MSB.
    localparam int MAX_HISTORY_LEN = 32;

    typedef logic [MAX_HISTORY_LEN-1:0] hist_word_t;

    // The newest outcome enters at bit 0.
    function automatic hist_word_t shift_in(input hist_word_t old_hist, input logic new_bit);
        return {old_hist[MAX_HISTORY_LEN-2:0], new_bit};
    endfunction

endpackage

// File: rtl/speculative_history_table_history_entry.sv
// One table entry: a speculative/committed history pair and all of its update rules.
module history_entry
    import speculative_history_table_pkg::*;
#(
    parameter int HISTORY_LEN = DEFAULT_HISTORY_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_spec_we,
    input  logic                   i_spec_taken,
    input  logic                   i_res_we,
    input  logic                   i_res_taken,
    input  logic                   i_res_mispredict,
    input  logic                   i_flush,
    output logic [HISTORY_LEN-1:0] o_spec_next,
    output logic [HISTORY_LEN-1:0] o_commit
);

    logic [HISTORY_LEN-1:0] r_spec;
    logic [HISTORY_LEN-1:0] r_commit;
    logic [HISTORY_LEN-1:0] w_commit_next;
    logic [HISTORY_LEN-1:0] w_spec_next;

    // Next-state values. Flush and repair both load the post-update committed
    // history and override a same-cycle speculative shift.
    always_comb begin
        w_commit_next = r_commit;
        w_spec_next   = r_spec;
        if (i_res_we) begin
            w_commit_next = HISTORY_LEN'(shift_in(MAX_HISTORY_LEN'(r_commit), i_res_taken));
        end
        if (i_flush || (i_res_we && i_res_mispredict)) begin
            w_spec_next = w_commit_next;
        end else if (i_spec_we) begin
            w_spec_next = HISTORY_LEN'(shift_in(MAX_HISTORY_LEN'(r_spec), i_spec_taken));
        end
    end

    // History state registers, cleared while reset is held low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_spec   <= '0;
            r_commit <= '0;
        end else begin
            r_spec   <= w_spec_next;
            r_commit <= w_commit_next;
        end
    end

    // The next speculative value feeds the read bypass at the top level.
    assign o_spec_next = w_spec_next;
    assign o_commit    = r_commit;

endmodule

// File: rtl/speculative_history_table.sv
// Per-PC speculative/committed branch history table with repair and flush.
module speculative_history_table
    import speculative_history_table_pkg::*;
#(
    parameter int INDEX_LEN   = DEFAULT_INDEX_LEN,
    parameter int HISTORY_LEN = DEFAULT_HISTORY_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_valid,
    input  logic [INDEX_LEN-1:0]   rd_index,
    output logic [HISTORY_LEN-1:0] rd_history,
    output logic                   rd_history_valid,
    input  logic                   spec_valid,
    input  logic [INDEX_LEN-1:0]   spec_index,
    input  logic                   spec_taken,
    input  logic                   res_valid,
    input  logic [INDEX_LEN-1:0]   res_index,
    input  logic                   res_taken,
    input  logic                   res_mispredict,
    output logic [HISTORY_LEN-1:0] res_history,
    input  logic                   flush
);

    localparam int DEPTH = 1 << INDEX_LEN;

    logic [HISTORY_LEN-1:0] w_spec_next [DEPTH];
    logic [HISTORY_LEN-1:0] w_commit    [DEPTH];
    logic [HISTORY_LEN-1:0] r_rd_history;
    logic                   r_rd_valid;

    // One entry per index; only the addressed entry sees its write enables.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic w_spec_we;
            logic w_res_we;

            assign w_spec_we = spec_valid && (spec_index == INDEX_LEN'(gi));
            assign w_res_we  = res_valid  && (res_index  == INDEX_LEN'(gi));

            history_entry #(
                .HISTORY_LEN (HISTORY_LEN)
            ) u_entry (
                .clk              (clk),
                .reset            (reset),
                .i_spec_we        (w_spec_we),
                .i_spec_taken     (spec_taken),
                .i_res_we         (w_res_we),
                .i_res_taken      (res_taken),
                .i_res_mispredict (res_mispredict),
                .i_flush          (flush),
                .o_spec_next      (w_spec_next[gi]),
                .o_commit         (w_commit[gi])
            );
        end
    endgenerate

    // Lookup result register: captures the entry value after this edge's updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_history <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= rd_valid;
            if (rd_valid) begin
                r_rd_history <= w_spec_next[rd_index];
            end
        end
    end

    assign rd_history       = r_rd_history;
    assign rd_history_valid = r_rd_valid;

    // Pre-update committed history for predictor training, independent of res_valid.
    assign res_history = w_commit[res_index];

endmodule

// File: tb/tb_speculative_history_table.sv
// Directed self-checking bench for speculative_history_table (INDEX_LEN=2, HISTORY_LEN=4).
module tb_speculative_history_table;

    logic       clk;
    logic       reset;
    logic       rd_valid;
    logic [1:0] rd_index;
    logic [3:0] rd_history;
    logic       rd_history_valid;
    logic       spec_valid;
    logic [1:0] spec_index;
    logic       spec_taken;
    logic       res_valid;
    logic [1:0] res_index;
    logic       res_taken;
    logic       res_mispredict;
    logic [3:0] res_history;
    logic       flush;

    int n_assert = 0;
    int n_fail   = 0;

    speculative_history_table #(
        .INDEX_LEN   (2),
        .HISTORY_LEN (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rd_valid         (rd_valid),
        .rd_index         (rd_index),
        .rd_history       (rd_history),
        .rd_history_valid (rd_history_valid),
        .spec_valid       (spec_valid),
        .spec_index       (spec_index),
        .spec_taken       (spec_taken),
        .res_valid        (res_valid),
        .res_index        (res_index),
        .res_taken        (res_taken),
        .res_mispredict   (res_mispredict),
        .res_history      (res_history),
        .flush            (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("check %-24s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_valid       = 1'b0;
        rd_index       = 2'd0;
        spec_valid     = 1'b0;
        spec_index     = 2'd0;
        spec_taken     = 1'b0;
        res_valid      = 1'b0;
        res_index      = 2'd0;
        res_taken      = 1'b0;
        res_mispredict = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic spec(input logic [1:0] idx, input logic tk);
        spec_valid = 1'b1;
        spec_index = idx;
        spec_taken = tk;
    endtask

    task automatic res(input logic [1:0] idx, input logic tk, input logic mp);
        res_valid      = 1'b1;
        res_index      = idx;
        res_taken      = tk;
        res_mispredict = mp;
    endtask

    // Plain lookup with no other traffic; checks the registered result.
    task automatic read_chk(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        idle();
        rd_valid = 1'b1;
        rd_index = idx;
        tick();
        idle();
        chk(tag, {4'b0, rd_history}, {4'b0, exp});
        chk({tag, "_vld"}, {7'b0, rd_history_valid}, 8'd1);
    endtask

    // Committed history seen combinationally with res_valid low.
    task automatic commit_chk(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        idle();
        res_index = idx;
        #1;
        chk(tag, {4'b0, res_history}, {4'b0, exp});
    endtask

    initial begin
        idle();
        reset = 1'b0;
        // Requests during reset must be ignored.
        spec(2'd0, 1'b1);
        res(2'd0, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_rd_history", {4'b0, rd_history}, 8'd0);
        chk("rst_rd_valid", {7'b0, rd_history_valid}, 8'd0);
        chk("rst_res_history", {4'b0, res_history}, 8'd0);
        idle();
        reset = 1'b1;

        // Three speculative updates to idx1, lookup alongside the third.
        spec(2'd1, 1'b1);
        tick();
        spec(2'd1, 1'b1);
        tick();
        chk("vld_low_no_rd", {7'b0, rd_history_valid}, 8'd0);
        spec(2'd1, 1'b0);
        rd_valid = 1'b1;
        rd_index = 2'd1;
        tick();
        idle();
        chk("spec3_rd", {4'b0, rd_history}, 8'b0110);
        chk("spec3_vld", {7'b0, rd_history_valid}, 8'd1);
        tick();
        chk("vld_pulse_once", {7'b0, rd_history_valid}, 8'd0);
        chk("rd_hold", {4'b0, rd_history}, 8'b0110);

        // Correct resolution: commit trains, speculative entry untouched.
        res(2'd1, 1'b1, 1'b0);
        #1;
        chk("res1_pre_hist", {4'b0, res_history}, 8'b0000);
        tick();
        commit_chk("res1_commit", 2'd1, 4'b0001);
        read_chk("res1_spec_kept", 2'd1, 4'b0110);

        // Mispredict repair collides with a spec update to the same entry.
        res(2'd1, 1'b0, 1'b1);
        spec(2'd1, 1'b1);
        rd_valid = 1'b1;
        rd_index = 2'd1;
        #1;
        chk("rep_pre_hist", {4'b0, res_history}, 8'b0001);
        tick();
        idle();
        chk("rep_bypass", {4'b0, rd_history}, 8'b0010);
        commit_chk("rep_commit", 2'd1, 4'b0010);
        read_chk("rep_spec", 2'd1, 4'b0010);

        // Build SPEC[2]=1011, COMMIT[2]=0001; first step also resolves idx2 (both apply).
        spec(2'd2, 1'b1);
        res(2'd2, 1'b1, 1'b0);
        tick();
        idle();
        spec(2'd2, 1'b0);
        tick();
        spec(2'd2, 1'b1);
        tick();
        spec(2'd2, 1'b1);
        tick();
        read_chk("pre_flush_spec2", 2'd2, 4'b1011);
        commit_chk("pre_flush_commit2", 2'd2, 4'b0001);

        // Lookup alongside a spec update from zero is bypassed.
        spec(2'd3, 1'b1);
        rd_valid = 1'b1;
        rd_index = 2'd3;
        tick();
        idle();
        chk("bypass_spec3", {4'b0, rd_history}, 8'b0001);
        spec(2'd3, 1'b1);
        tick();
        read_chk("spec3_0011", 2'd3, 4'b0011);

        // Flush with a spec update to idx2 (dropped) and a resolve on idx3 (visible).
        flush = 1'b1;
        spec(2'd2, 1'b1);
        res(2'd3, 1'b1, 1'b0);
        rd_valid = 1'b1;
        rd_index = 2'd2;
        tick();
        idle();
        chk("flush_bypass2", {4'b0, rd_history}, 8'b0001);
        read_chk("flush_spec2", 2'd2, 4'b0001);
        read_chk("flush_spec3", 2'd3, 4'b0001);
        read_chk("flush_spec1", 2'd1, 4'b0010);

        // Sub-cycle reset pulse mid-traffic clears everything immediately.
        spec(2'd0, 1'b1);
        tick();
        spec(2'd0, 1'b1);
        res(2'd0, 1'b1, 1'b0);
        rd_valid = 1'b1;
        rd_index = 2'd0;
        tick();
        chk("pre_rst_vld", {7'b0, rd_history_valid}, 8'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_rd_history", {4'b0, rd_history}, 8'd0);
        chk("arst_rd_valid", {7'b0, rd_history_valid}, 8'd0);
        chk("arst_res_history", {4'b0, res_history}, 8'd0);
        #1;
        reset = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) begin
            read_chk($sformatf("arst_spec%0d", i), 2'(i), 4'b0000);
            commit_chk($sformatf("arst_commit%0d", i), 2'(i), 4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
